// File: rtl/sequenciador_medidas.sv
// ============================================================================
// sequenciador_medidas
// ----------------------------------------------------------------------------
// Periodic measurement sequencer for an HC-SR04 ultrasonic interface. While
// ligar is high, it sends a one-cycle medir pulse and waits for pronto. On
// pronto it stores medida and raises valida. If pronto does not arrive in
// time, it pulses reset_sensor and sets the sticky erro_timeout flag. After
// either outcome it waits INTERVALO cycles before the next measurement.
//
// Parameters
//   INTERVALO : cycles from the end of one measurement to the next trigger
//   TIMEOUT   : cycles allowed in espera_pronto before declaring a failure
//   LIMIAR    : proximity threshold (alerta = medida < LIMIAR, unsigned)
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   ligar          in   level enable for periodic measurement
//   pronto         in   measurement-done strobe (honoured in espera_pronto only)
//   medida[11:0]   in   measurement value, valid while pronto=1
//   medir          out  one-cycle start pulse to the interface
//   reset_sensor   out  one-cycle reset pulse to the interface on timeout
//   ultima_medida  out  last valid measurement
//   valida         out  one-cycle new-measurement strobe
//   alerta         out  last valid measurement below LIMIAR
//   erro_timeout   out  sticky timeout flag, cleared by the next valid measurement
//   contagem[7:0]  out  count of valid measurements (wraps)
//   db_estado[3:0] out  current FSM state code
// ============================================================================
module sequenciador_medidas #(
    parameter int          INTERVALO = 50_000_000,
    parameter int          TIMEOUT   = 3_500_000,
    parameter logic [11:0] LIMIAR    = 12'h020
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic [11:0] medida,
    output logic        medir,
    output logic        reset_sensor,
    output logic [11:0] ultima_medida,
    output logic        valida,
    output logic        alerta,
    output logic        erro_timeout,
    output logic [7:0]  contagem,
    output logic [3:0]  db_estado
);

    localparam int unsigned TW = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;
    localparam int unsigned IW = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IV_LAST = IW'(INTERVALO - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        DISPARA       = 4'd1,
        ESPERA_PRONTO = 4'd2,
        ARMAZENA      = 4'd3,
        FALHA         = 4'd4,
        AGUARDA       = 4'd5
    } estado_t;

    estado_t       r_estado;
    logic [TW-1:0] r_cnt_to;
    logic [IW-1:0] r_cnt_int;
    logic          r_medir;
    logic          r_reset_sensor;
    logic          r_valida;
    logic          r_alerta;
    logic          r_erro;
    logic [11:0]   r_ultima;
    logic [7:0]    r_contagem;

    // The strobes and stored values change on the edge that enters their
    // state. This way each strobe lines up exactly with the matching
    // db_estado code, while every output still comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado       <= INICIAL;
            r_cnt_to       <= '0;
            r_cnt_int      <= '0;
            r_medir        <= 1'b0;
            r_reset_sensor <= 1'b0;
            r_valida       <= 1'b0;
            r_alerta       <= 1'b0;
            r_erro         <= 1'b0;
            r_ultima       <= '0;
            r_contagem     <= '0;
        end else begin
            r_medir        <= 1'b0;
            r_reset_sensor <= 1'b0;
            r_valida       <= 1'b0;
            case (r_estado)
                INICIAL: begin
                    if (ligar) begin
                        r_estado <= DISPARA;
                        r_medir  <= 1'b1;
                    end
                end
                DISPARA: begin
                    r_cnt_to <= '0;
                    r_estado <= ESPERA_PRONTO;
                end
                ESPERA_PRONTO: begin
                    // Hold the counter at its terminal value so it cannot wrap.
                    if (r_cnt_to != TO_LAST) begin
                        r_cnt_to <= r_cnt_to + 1'b1;
                    end
                    // pronto is checked first, so it wins when it arrives in
                    // the same cycle as the timeout.
                    if (pronto) begin
                        r_estado   <= ARMAZENA;
                        r_valida   <= 1'b1;
                        r_ultima   <= medida;
                        r_alerta   <= (medida < LIMIAR);
                        r_contagem <= r_contagem + 8'd1;
                        r_erro     <= 1'b0;
                    end else if (r_cnt_to == TO_LAST) begin
                        r_estado       <= FALHA;
                        r_reset_sensor <= 1'b1;
                        r_erro         <= 1'b1;
                    end
                end
                ARMAZENA, FALHA: begin
                    r_cnt_int <= '0;
                    r_estado  <= AGUARDA;
                end
                AGUARDA: begin
                    if (!ligar) begin
                        r_estado <= INICIAL;
                    end else if (r_cnt_int == IV_LAST) begin
                        r_estado <= DISPARA;
                        r_medir  <= 1'b1;
                    end else begin
                        r_cnt_int <= r_cnt_int + 1'b1;
                    end
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign medir         = r_medir;
    assign reset_sensor  = r_reset_sensor;
    assign valida        = r_valida;
    assign alerta        = r_alerta;
    assign erro_timeout  = r_erro;
    assign ultima_medida = r_ultima;
    assign contagem      = r_contagem;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_sequenciador_medidas.sv
// ============================================================================
// tb_sequenciador_medidas
// ----------------------------------------------------------------------------
// Directed plus randomized bench for sequenciador_medidas. A transaction-level
// reference (last value, alert, count, error flag) is updated per measurement,
// and protocol timing is checked by counting cycles between strobes. A second
// instance with short intervals exercises the contagem wrap.
// ============================================================================
module tb_sequenciador_medidas;

    localparam int          INTERVALO = 1000;
    localparam int          TIMEOUT   = 5000;
    localparam logic [11:0] LIMIAR    = 12'h020;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ligar = 1'b0;
    logic        pronto = 1'b0;
    logic [11:0] medida = '0;
    logic        medir, reset_sensor, valida, alerta, erro_timeout;
    logic [11:0] ultima_medida;
    logic [7:0]  contagem;
    logic [3:0]  db_estado;

    logic        ligar2 = 1'b0;
    logic        pronto2 = 1'b0;
    logic [11:0] medida2 = '0;
    logic        medir2, reset_sensor2, valida2, alerta2, erro_timeout2;
    logic [11:0] ultima_medida2;
    logic [7:0]  contagem2;
    logic [3:0]  db_estado2;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level reference state
    logic [11:0] m_ultima = '0;
    logic        m_alerta = 1'b0;
    int          m_cont   = 0;
    logic        m_erro   = 1'b0;

    always #5 clock = ~clock;

    sequenciador_medidas #(
        .INTERVALO(INTERVALO),
        .TIMEOUT  (TIMEOUT),
        .LIMIAR   (LIMIAR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar),
        .pronto       (pronto),
        .medida       (medida),
        .medir        (medir),
        .reset_sensor (reset_sensor),
        .ultima_medida(ultima_medida),
        .valida       (valida),
        .alerta       (alerta),
        .erro_timeout (erro_timeout),
        .contagem     (contagem),
        .db_estado    (db_estado)
    );

    sequenciador_medidas #(
        .INTERVALO(4),
        .TIMEOUT  (16),
        .LIMIAR   (12'h020)
    ) dut2 (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar2),
        .pronto       (pronto2),
        .medida       (medida2),
        .medir        (medir2),
        .reset_sensor (reset_sensor2),
        .ultima_medida(ultima_medida2),
        .valida       (valida2),
        .alerta       (alerta2),
        .erro_timeout (erro_timeout2),
        .contagem     (contagem2),
        .db_estado    (db_estado2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ultima"}, 32'(ultima_medida), 32'(m_ultima));
        chk({tag, "_alerta"}, 32'(alerta), 32'(m_alerta));
        chk({tag, "_cont"},   32'(contagem), 32'(m_cont % 256));
        chk({tag, "_erro"},   32'(erro_timeout), 32'(m_erro));
    endtask

    // Waits for medir, driving random pronto noise that must be ignored.
    task automatic wait_medir(input bit chk_gap, input int exp_gap);
        int n;
        bit spur;
        n = 0;
        spur = 1'b0;
        while (medir !== 1'b1 && n < 3 * INTERVALO) begin
            pronto = 1'($urandom_range(0, 1));
            medida = 12'($urandom);
            tick();
            n++;
            if (valida === 1'b1) spur = 1'b1;
        end
        pronto = 1'b0;
        chk("medir_seen", 32'(medir), 32'd1);
        chk("dispara_code", 32'(db_estado), 32'd1);
        chk("spurious_valida", 32'(spur), 32'd0);
        if (chk_gap) chk("gap_to_medir", n, exp_gap);
    endtask

    // One full measurement. d=0: no pronto (timeout); d>0: pronto in the
    // d-th espera_pronto cycle. drop=1 releases ligar right after medir.
    task automatic do_meas(input bit chk_gap, input int exp_gap, input int d,
                           input logic [11:0] v, input bit drop);
        int n;
        wait_medir(chk_gap, exp_gap);
        if (drop) ligar = 1'b0;
        tick();
        chk("medir_one_cycle", 32'(medir), 32'd0);
        if (d == 0) begin
            n = 0;
            while (reset_sensor !== 1'b1 && n < TIMEOUT + 10) begin
                tick();
                n++;
            end
            m_erro = 1'b1;
            chk("timeout_latency", n, TIMEOUT);
            chk("falha_valida", 32'(valida), 32'd0);
            chk("falha_code", 32'(db_estado), 32'd4);
            chk_model("falha");
            tick();
            chk("reset_sensor_one_cycle", 32'(reset_sensor), 32'd0);
        end else begin
            repeat (d - 1) tick();
            pronto = 1'b1;
            medida = v;
            tick();
            pronto = 1'b0;
            medida = 12'($urandom);
            m_ultima = v;
            m_alerta = (v < LIMIAR);
            m_cont   = m_cont + 1;
            m_erro   = 1'b0;
            chk("armazena_valida", 32'(valida), 32'd1);
            chk("armazena_no_reset_sensor", 32'(reset_sensor), 32'd0);
            chk("armazena_code", 32'(db_estado), 32'd3);
            chk_model("armazena");
            tick();
            chk("valida_one_cycle", 32'(valida), 32'd0);
        end
        chk("aguarda_code", 32'(db_estado), 32'd5);
    endtask

    initial begin
        int n;
        int d;
        bit seen;
        logic [11:0] v;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_medir", 32'(medir), 32'd0);
        chk("rst_reset_sensor", 32'(reset_sensor), 32'd0);
        chk("rst_valida", 32'(valida), 32'd0);
        chk("rst_code", 32'(db_estado), 32'd0);
        chk_model("rst");

        // Idle without ligar
        repeat (20) tick();
        chk("idle_no_medir", 32'(medir), 32'd0);
        chk("idle_code", 32'(db_estado), 32'd0);

        // Basic measurement, then near / boundary values
        ligar = 1'b1;
        do_meas(1'b1, 1, 200, 12'h100, 1'b0);
        do_meas(1'b1, INTERVALO, 37, 12'h01F, 1'b0);
        do_meas(1'b1, INTERVALO, 1, 12'h020, 1'b0);

        // Timeout, then race of pronto with the last timeout cycle
        do_meas(1'b1, INTERVALO, 0, 12'h000, 1'b0);
        do_meas(1'b1, INTERVALO, TIMEOUT, 12'h005, 1'b0);

        // Randomized measurements
        for (int k = 0; k < 8; k++) begin
            d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 600));
            v = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63)) : 12'($urandom);
            do_meas(1'b1, INTERVALO, d, v, 1'b0);
        end

        // ligar dropped during espera_pronto: completes, then back to inicial
        do_meas(1'b1, INTERVALO, 50, 12'h0AB, 1'b1);
        tick();
        chk("drop_inicial_code", 32'(db_estado), 32'd0);
        seen = 1'b0;
        repeat (INTERVALO + 200) begin
            tick();
            if (medir === 1'b1) seen = 1'b1;
        end
        chk("drop_no_medir", 32'(seen), 32'd0);
        chk_model("drop_hold");

        // Reset pulsed during espera_pronto abandons the measurement
        ligar = 1'b1;
        wait_medir(1'b1, 1);
        repeat (10) tick();
        chk("pre_reset_espera_code", 32'(db_estado), 32'd2);
        reset = 1'b1;
        ligar = 1'b0;
        tick();
        reset = 1'b0;
        m_ultima = '0;
        m_alerta = 1'b0;
        m_cont   = 0;
        m_erro   = 1'b0;
        chk("midrst_medir", 32'(medir), 32'd0);
        chk("midrst_reset_sensor", 32'(reset_sensor), 32'd0);
        chk("midrst_valida", 32'(valida), 32'd0);
        chk("midrst_code", 32'(db_estado), 32'd0);
        chk_model("midrst");
        seen = 1'b0;
        repeat (TIMEOUT + 100) begin
            pronto = 1'($urandom_range(0, 1));
            tick();
            if (valida === 1'b1 || reset_sensor === 1'b1 || medir === 1'b1) seen = 1'b1;
        end
        pronto = 1'b0;
        chk("midrst_quiet", 32'(seen), 32'd0);

        // contagem wrap on the short-interval instance
        ligar2 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (medir2 !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            chk("wrap_medir_seen", 32'(medir2), 32'd1);
            tick();
            pronto2 = 1'b1;
            medida2 = 12'($urandom);
            tick();
            pronto2 = 1'b0;
            chk("wrap_valida", 32'(valida2), 32'd1);
            chk("wrap_cont", 32'(contagem2), 32'((i + 1) % 256));
        end
        chk("wrap_zero", 32'(contagem2), 32'd0);
        ligar2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sequenciador_medidas.md
SEQUENCIADOR_MEDIDAS -- requirements
Module: sequenciador_medidas

Interface
REQ-001 SHALL have parameter INTERVALO, default 50_000_000: clock cycles from the end of one measurement to the next trigger (1 s at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 3_500_000: cycles allowed between the medir pulse and pronto (70 ms).
REQ-003 SHALL have parameter LIMIAR, default 12'h020: proximity threshold; a measurement is near when medida < LIMIAR, unsigned compare.
REQ-004 SHALL have port clock, input, 1 bit: 50 MHz system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ligar, input, 1 bit: level-enable for periodic measurement.
REQ-007 SHALL have port pronto, input, 1 bit: measurement-done strobe from the HC-SR04 interface.
REQ-008 SHALL have port medida, input, 12 bits: measurement from the interface; valid while pronto=1.
REQ-009 SHALL have port medir, output, 1 bit: start pulse to the interface.
REQ-010 SHALL have port reset_sensor, output, 1 bit: reset pulse to the interface.
REQ-011 SHALL have port ultima_medida, output, 12 bits: last valid measurement.
REQ-012 SHALL have port valida, output, 1 bit: new-measurement strobe.
REQ-013 SHALL have port alerta, output, 1 bit: last valid measurement is below LIMIAR.
REQ-014 SHALL have port erro_timeout, output, 1 bit: sticky error flag for a missing pronto.
REQ-015 SHALL have port contagem, output, 8 bits: count of valid measurements.
REQ-016 SHALL have port db_estado, output, 4 bits: current FSM state code.

Function
REQ-017 SHALL implement an FSM with the states and db_estado codes below.
- inicial = 0
- dispara = 1
- espera_pronto = 2
- armazena = 3
- falha = 4
- aguarda = 5
- Any unused code SHALL return to inicial on the next cycle.
REQ-018 inicial: the FSM SHALL go to dispara on the next edge when ligar=1, and SHALL stay in inicial otherwise.
REQ-019 dispara: the FSM SHALL stay exactly one cycle with medir=1, clear the timeout counter, and go to espera_pronto; medir SHALL be 0 in every other state.
REQ-020 espera_pronto: the timeout counter SHALL increment every cycle.
- If pronto=1, the FSM SHALL go to armazena.
- Otherwise, when the counter reaches TIMEOUT-1, the FSM SHALL go to falha.
- If pronto and the timeout occur in the same cycle, pronto SHALL win.
REQ-021 armazena (one cycle): the block SHALL capture medida, sampled in the cycle pronto=1, into ultima_medida; assert valida for exactly this cycle; increment contagem (wrapping 255 -> 0); and clear erro_timeout. The FSM SHALL then go to aguarda.
REQ-022 alerta SHALL be registered at the armazena transition as (captured medida < LIMIAR) and SHALL hold until the next armazena.
REQ-023 falha (one cycle): the block SHALL assert reset_sensor for exactly this cycle, set erro_timeout (held until the next armazena), leave ultima_medida, alerta and contagem unchanged, and go to aguarda.
REQ-024 aguarda: the interval counter SHALL count INTERVALO cycles, then the FSM SHALL go to dispara; if ligar=0 in any aguarda cycle, the FSM SHALL go to inicial instead.
REQ-025 ligar=0 during dispara or espera_pronto SHALL NOT abort the measurement; it completes through armazena/falha, then aguarda detects ligar=0.
REQ-026 Counter widths SHALL be sized by $clog2 of their parameter; neither counter SHALL overflow before its terminal value.
REQ-027 pronto SHALL be ignored in every state except espera_pronto.

Reset
REQ-028 With reset=1 at a rising edge, the FSM SHALL enter inicial and set these values.
- medir, reset_sensor, valida, alerta, erro_timeout = 0
- ultima_medida = 12'h000, contagem = 8'h00, db_estado = 4'h0
- both counters = 0
REQ-029 Reset asserted mid-measurement SHALL abandon it: no valida, no contagem change, no reset_sensor pulse.

Verification (INTERVALO=1000, TIMEOUT=5000, LIMIAR=12'h020)
REQ-030 Basic measurement: reset, then ligar=1; pronto=1 with medida=12'h100 200 cycles after medir.
- Required: medir high one cycle, then valida one cycle.
- Required: ultima_medida=12'h100, alerta=0, contagem=1.
- Required: next medir exactly 1000 cycles after armazena.
REQ-031 Near object: medida=12'h01F -> alerta=1. Then medida=12'h020 -> alerta=0.
REQ-032 Timeout: no pronto after medir -> falha exactly 5000 cycles later.
- Required: reset_sensor one cycle, erro_timeout=1, ultima_medida and contagem unchanged.
- Required: the following successful measurement clears erro_timeout.
REQ-033 Race: pronto on the cycle the timeout counter reaches 4999 -> armazena taken, no reset_sensor.
REQ-034 Enable handling:
- ligar dropped during espera_pronto -> the measurement completes (valida), then the FSM returns to inicial with no further medir.
- 256 successful measurements -> contagem wraps to 0.
REQ-035 Reset mid-operation: reset pulsed during espera_pronto -> all outputs at reset values next cycle, db_estado=0.
